// File: rtl/qpsk_frame_pack_if.sv
// Byte-in / frame-out bundle between a payload source and qpsk_frame_pack.
// master: payload source (drives byte_in/byte_valid, observes everything else).
// slave:  the packer (accepts bytes, drives para_out and the status pulses/count).
interface qpsk_frame_pack_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [39:0] para_out;
  logic        frame_start;
  logic        underrun;
  logic [15:0] underrun_cnt;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, para_out, frame_start, underrun, underrun_cnt
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, para_out, frame_start, underrun, underrun_cnt
  );
endinterface

// File: rtl/qpsk_frame_pack.sv
// qpsk_frame_pack: collects three payload bytes into a shadow and, once per
// FRAME_CYCLES-clock frame period, presents {HEAD, b0, b1, b2, TAIL} on para_out.
// Ports: clk, rst (async, active-high), bus (slave modport: byte_in/byte_valid/
// byte_ready in, para_out/frame_start/underrun/underrun_cnt out).
// Latency: completed frame appears at the first period tick after completion
// (>= 1 clock). Backpressure: byte_ready is low while a complete frame waits
// for its tick; it comes straight from the state register.
// Optional build macro QPSK_FRAME_IDLE_FILL_EN: on underrun send an idle frame
// instead of repeating the previous one.
module qpsk_frame_pack #(
  parameter logic [7:0] HEAD         = 8'hFF,
  parameter logic [7:0] TAIL         = 8'hFF,
  parameter int         FRAME_CYCLES = 20000,
  parameter logic [7:0] IDLE_BYTE    = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  qpsk_frame_pack_if.slave   bus
);

  localparam logic [15:0] LAST_CNT = 16'(FRAME_CYCLES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] frame_cnt;
  logic [1:0]  idx_q;
  logic [23:0] shadow_q;
  logic [39:0] para_q;
  logic        frame_start_q;
  logic        underrun_q;
  logic [15:0] ucnt;
  logic        ready;
  logic        tick;
  logic        accept;

  assign ready  = (state_q == COLLECT);
  assign tick   = (frame_cnt == LAST_CNT);
  assign accept = bus.byte_valid && ready;

  // Next-state: a tick coinciding with the 3rd byte still sees COLLECT, so
  // it is an underrun and the freshly completed frame waits one more period.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (accept && idx_q == 2'd2) state_d = FULL;
      FULL:    if (tick) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Frame period timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       frame_cnt <= '0;
    else if (tick) frame_cnt <= '0;
    else           frame_cnt <= frame_cnt + 16'd1;
  end

  // Shadow collection. Accept and a FULL-state tick are mutually exclusive
  // because ready is low in FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      idx_q    <= '0;
    end else if (accept) begin
      unique case (idx_q)
        2'd0:    shadow_q[23:16] <= bus.byte_in;
        2'd1:    shadow_q[15:8]  <= bus.byte_in;
        default: shadow_q[7:0]   <= bus.byte_in;
      endcase
      idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else if (tick && state_q == FULL) begin
      shadow_q <= '0;
    end
  end

  // Output frame and status; everything here moves only on tick edges,
  // except the pulses which clear on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      para_q        <= {HEAD, 24'h000000, TAIL};
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      ucnt          <= '0;
    end else begin
      frame_start_q <= tick;
      underrun_q    <= tick && (state_q == COLLECT);
      if (tick) begin
        if (state_q == FULL) begin
          para_q <= {HEAD, shadow_q, TAIL};
        end else begin
`ifdef QPSK_FRAME_IDLE_FILL_EN
          para_q <= {HEAD, IDLE_BYTE, IDLE_BYTE, IDLE_BYTE, TAIL};
`endif
          if (ucnt != 16'hFFFF) ucnt <= ucnt + 16'd1;
        end
      end
    end
  end

`ifndef QPSK_FRAME_IDLE_FILL_EN
  // Idle byte only matters in the idle-fill build.
  logic [7:0] unused_idle;
  assign unused_idle = IDLE_BYTE;
`endif

  assign bus.byte_ready   = ready;
  assign bus.para_out     = para_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = ucnt;

endmodule

// File: tb/tb_qpsk_frame_pack.sv
// Bench for qpsk_frame_pack: directed scenarios plus random traffic, every
// cycle compared against a queue-based model of the frame packing rules.
// FRAME_CYCLES = 16, IDLE_BYTE = 8'h00.
module tb_qpsk_frame_pack;

  localparam int FC = 16;

  logic clk = 1'b0;
  logic rst;

  qpsk_frame_pack_if bus ();

  qpsk_frame_pack #(
    .HEAD(8'hFF), .TAIL(8'hFF), .FRAME_CYCLES(FC), .IDLE_BYTE(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  pend[$];     // bytes accepted but not yet sent
  logic [39:0] m_para;
  logic        m_fs;
  logic        m_ur;
  int          m_ucnt;
  int          edges;       // clock edges since reset release
  bit          m_acc;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("para_out",     bus.para_out, m_para);
    chk("frame_start",  40'(bus.frame_start), 40'(m_fs));
    chk("underrun",     40'(bus.underrun), 40'(m_ur));
    chk("underrun_cnt", 40'(bus.underrun_cnt), 40'(m_ucnt));
    chk("byte_ready",   40'(bus.byte_ready), 40'(pend.size() < 3));
  endtask

  task automatic model_reset();
    pend.delete();
    m_para = 40'hFF000000FF;
    m_fs   = 1'b0;
    m_ur   = 1'b0;
    m_ucnt = 0;
    edges  = 0;
    m_acc  = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(input bit v, input logic [7:0] d);
    bit tick;
    bit full;
    bus.byte_valid = v;
    bus.byte_in    = d;
    tick  = ((edges + 1) % FC) == 0;
    full  = (pend.size() == 3);
    m_acc = v && !full;
    m_fs  = tick;
    m_ur  = tick && !full;
    if (tick) begin
      if (full) begin
        m_para = {8'hFF, pend[0], pend[1], pend[2], 8'hFF};
        pend.delete();
      end else begin
`ifdef QPSK_FRAME_IDLE_FILL_EN
        m_para = {8'hFF, 24'h000000, 8'hFF};
`endif
        if (m_ucnt < 65535) m_ucnt++;
      end
    end
    if (m_acc) pend.push_back(d);
    edges++;
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  // Hold valid until the byte is taken, bounded.
  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    do begin
      step(1'b1, d);
      n++;
    end while (!m_acc && n < 64);
    chk("accept_bound", 40'(m_acc), 40'd1);
  endtask

  // Called at posedge+1; asserts reset asynchronously, releases after one edge.
  task automatic pulse_reset();
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_para_out",     bus.para_out, 40'hFF000000FF);
    chk("rst_frame_start",  40'(bus.frame_start), 40'd0);
    chk("rst_underrun",     40'(bus.underrun), 40'd0);
    chk("rst_underrun_cnt", 40'(bus.underrun_cnt), 40'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_byte_ready", 40'(bus.byte_ready), 40'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (pend.size() != 0 && n < 4 * FC) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("drain_bound", 40'(pend.size()), 40'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    #2;
    pulse_reset();

    // First frame before the first tick
    send_byte(8'h17); send_byte(8'h18); send_byte(8'h19);
    idle(FC - 3);
    chk("first_frame", bus.para_out, 40'hFF171819FF);
    chk("first_frame_start", 40'(bus.frame_start), 40'd1);

    // No input for a whole period -> underrun
    idle(FC);
    chk("underrun_pulse", 40'(bus.underrun), 40'd1);
    chk("underrun_count", 40'(bus.underrun_cnt), 40'd1);

    // Continuous valid, bytes 01..09
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    drain();

    // Third byte accepted exactly on the tick edge
    send_byte(8'h31); send_byte(8'h32);
    begin
      int n = 0;
      while (((edges + 1) % FC) != 0 && n < FC) begin
        step(1'b0, 8'h00);
        n++;
      end
    end
    step(1'b1, 8'h33);
    chk("coincide_accept", 40'(m_acc), 40'd1);
    chk("coincide_underrun", 40'(bus.underrun), 40'd1);
    idle(FC);
    chk("coincide_frame", bus.para_out, 40'hFF313233FF);

    // Reset mid-period with a partial shadow
    idle(5);
    send_byte(8'h51); send_byte(8'h52);
    pulse_reset();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(FC - 3);
    chk("post_rst_frame", bus.para_out, 40'hFFAABBCCFF);

    // Random traffic
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, 8'($urandom));
    pulse_reset();
    for (int i = 0; i < 300; i++) step($urandom_range(0, 4) == 0, 8'($urandom));

    // Counter saturation from a preloaded near-full value
    force dut.ucnt = 16'hFFFD;
    #1;
    release dut.ucnt;
    m_ucnt = 65533;
    idle(4 * FC);
    chk("ucnt_saturated", 40'(bus.underrun_cnt), 40'h000000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpsk_frame_pack.md
Name: qpsk_frame_pack

Overview:
- Upstream feeder for the QPSK modulator.
- Accepts payload bytes over a valid/ready handshake and packs three of them into a 40-bit frame: {HEAD, b0, b1, b2, TAIL}.
- Presents the frame on a parallel bus that stays stable for exactly FRAME_CYCLES clocks, which is the time the modulator takes to consume one 40-bit word.
- Double-buffered: the next frame is collected while the current one is transmitted.

Parameters:
- HEAD, 8'hFF, frame header byte at bits [39:32].
- TAIL, 8'hFF, frame tail byte at bits [7:0].
- FRAME_CYCLES, 20000, clocks per frame period; legal range 8..65535.
- IDLE_BYTE, 8'h00, payload filler used by the optional idle-fill feature.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- byte_in  in  8  payload byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  packer can accept a byte.
- para_out  out  40  frame to the modulator's para_in.
- frame_start  out  1  one-cycle pulse in the first cycle a new para_out value is presented.
- underrun  out  1  one-cycle pulse when a frame boundary finds no complete frame.
- underrun_cnt  out  16  saturating count of underruns.

Behaviour:
- Reset (async assert, synchronous-edge release):
  - para_out = {HEAD, 24'h000000, TAIL}.
  - frame_start = 0, underrun = 0, underrun_cnt = 0.
  - frame_cnt = 0; shadow empty (byte index 0, full flag 0).
  - Asserting rst mid-frame discards any partial or complete shadow and restarts the frame period.
- Frame timer:
  - frame_cnt counts 0..FRAME_CYCLES-1 and wraps to 0.
  - The "tick" is the rising edge at which frame_cnt == FRAME_CYCLES-1.
  - The first tick occurs FRAME_CYCLES clocks after reset release.
- Byte path:
  - byte_ready = !shadow_full, driven directly from a register with no combinational path from byte_valid.
  - A byte is accepted on a rising edge where byte_valid && byte_ready.
  - The 1st accepted byte goes to shadow[23:16] (b0), the 2nd to [15:8] (b1), the 3rd to [7:0] (b2).
  - Accepting the 3rd byte sets shadow_full; byte_ready falls in the following cycle.
- States: COLLECT (shadow_full = 0, index 0..2) and FULL (shadow_full = 1, waiting for tick).
  - COLLECT -> FULL on the 3rd byte accept.
  - FULL -> COLLECT on tick.
- At tick with shadow_full = 1:
  - para_out <= {HEAD, shadow, TAIL}.
  - Shadow cleared; byte_ready = 1 from the next cycle.
  - frame_start = 1 in the cycle where frame_cnt == 0.
- At tick with shadow_full = 0 (underrun):
  - underrun = 1 and frame_start = 1 in the next cycle.
  - underrun_cnt increments, saturating at 16'hFFFF.
  - para_out is updated per the Optional Feature.
  - Partially collected bytes are kept and the index is unchanged.
- Simultaneous tick and 3rd-byte accept: the tick samples shadow_full = 0 and is treated as an underrun. The byte is still accepted, so shadow becomes full and is sent at the next tick.
- Latency: a frame completed at edge N appears on para_out at the first tick after N. The minimum is 1 clock when completion occurs on the edge before the tick.
- para_out changes only at tick edges and is never glitch-updated mid-period.

Optional Feature:
- Macro: QPSK_FRAME_IDLE_FILL_EN.
- Defined: on underrun, para_out <= {HEAD, IDLE_BYTE, IDLE_BYTE, IDLE_BYTE, TAIL}.
- Undefined: on underrun, para_out holds its previous value, so the last frame is repeated.
- underrun, frame_start and underrun_cnt behave identically in both builds.

Test Plan (FRAME_CYCLES = 16, IDLE_BYTE = 8'h00):
- Reset, then send 8'h17, 8'h18, 8'h19 back-to-back before the first tick -> at cycle 16 after release, para_out = 40'hFF171819FF, frame_start = 1 for exactly 1 cycle, underrun = 0.
- Hold byte_valid = 1 continuously with bytes 01..09 -> byte_ready drops after every 3rd byte; consecutive frames are FF010203FF, FF040506FF, FF070809FF, spaced exactly 16 cycles apart.
- No input after the first frame FF171819FF -> at the next tick underrun = 1 and underrun_cnt = 1; para_out = FF000000FF with the macro defined, FF171819FF without it.
- 3rd byte accepted exactly on the tick edge -> underrun pulses, and that frame appears one period later (16 cycles).
- Send 2 bytes, pulse rst for 1 cycle mid-period, then send AA, BB, CC -> next frame is FFAABBCCFF, and para_out = FF000000FF immediately after rst asserts (asynchronous).
- Force 65536 underruns (or preload the counter in the bench) -> underrun_cnt stays at 16'hFFFF.
